// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared encodings for the unified memory arbiter: FSM states,
//               requester IDs and the downstream operation type.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Arbiter FSM state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // Requester that owns the single outstanding transaction
  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  // Downstream operation
  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_e;

endpackage
`default_nettype wire

// File: rtl/mem_arb_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_timeout_counter
// Description : Transaction watchdog. Cleared when a transaction starts,
//               counts while enabled and flags expiry at TIMEOUT_CYCLES-1.
//               Kept generic so other memory ports can reuse it.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] c_limit = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // Count enabled cycles, holding at the limit so expiry cannot wrap away
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != c_limit)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == c_limit);

endmodule
`default_nettype wire

// File: rtl/unified_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : unified_memory_arbiter
// Description : Shares one downstream memory port between the core fetch and
//               data interfaces. Single outstanding transaction, data has
//               priority bounded by a fetch-starvation streak limit, and a
//               response timeout raises an access fault to the owner.
// Revision    : 1.0 - initial release
// ============================================================================
module unified_memory_arbiter #(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDRESS_BITS    = 64,
  parameter int NUM_BYTES       = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  // core fetch interface
  input  logic                    fetch_read,
  input  logic [ADDRESS_BITS-1:0] fetch_address_out,
  output logic                    fetch_ready,
  output logic                    fetch_valid,
  output logic [DATA_WIDTH-1:0]   fetch_data_in,
  output logic [ADDRESS_BITS-1:0] fetch_address_in,
  // core data interface
  input  logic                    memory_read,
  input  logic                    memory_write,
  input  logic [NUM_BYTES-1:0]    memory_byte_en,
  input  logic [ADDRESS_BITS-1:0] memory_address_out,
  input  logic [DATA_WIDTH-1:0]   memory_data_out,
  output logic                    memory_ready,
  output logic                    memory_valid,
  output logic [DATA_WIDTH-1:0]   memory_data_in,
  output logic [ADDRESS_BITS-1:0] memory_address_in,
  // access faults
  output logic                    i_mem_access_fault,
  output logic                    d_mem_access_fault,
  // downstream command
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [NUM_BYTES-1:0]    mem_byte_en,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]   mem_data_out,
  input  logic                    mem_ready,
  // downstream response
  input  logic                    mem_valid,
  input  logic [DATA_WIDTH-1:0]   mem_data_in,
  input  logic [ADDRESS_BITS-1:0] mem_address_in
);

  import mem_arb_pkg::*;

  localparam int SW = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
  localparam logic [SW-1:0] c_streak_max = SW'(MAX_DATA_STREAK);

  arb_state_e    r_state;
  logic          r_req_id;
  logic [SW-1:0] r_streak;

  logic    w_fetch_pend;
  logic    w_data_pend;
  logic    w_grant_data;
  logic    w_timer_clear;
  logic    w_timer_enable;
  logic    w_expired;
  mem_op_e w_data_op;

  assign w_fetch_pend = fetch_read;
  assign w_data_pend  = memory_read | memory_write;
  // Data wins unless fetch has been passed over MAX_DATA_STREAK times in a row
  assign w_grant_data = w_data_pend && (!w_fetch_pend || (r_streak != c_streak_max));
  // A simultaneous read+write is treated as a write
  assign w_data_op    = memory_write ? OP_WRITE : OP_READ;

  assign fetch_ready  = (r_state == IDLE);
  assign memory_ready = (r_state == IDLE);

  assign w_timer_clear  = (r_state == IDLE) && (w_fetch_pend || w_data_pend);
  assign w_timer_enable = (r_state == ISSUE) || (r_state == WAIT);

  mem_arb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (w_timer_clear),
    .enable  (w_timer_enable),
    .expired (w_expired)
  );

  // Arbitration FSM with all core-side and downstream outputs registered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state            <= IDLE;
      r_req_id           <= REQ_FETCH;
      r_streak           <= '0;
      fetch_valid        <= 1'b0;
      fetch_data_in      <= '0;
      fetch_address_in   <= '0;
      memory_valid       <= 1'b0;
      memory_data_in     <= '0;
      memory_address_in  <= '0;
      i_mem_access_fault <= 1'b0;
      d_mem_access_fault <= 1'b0;
      mem_read           <= 1'b0;
      mem_write          <= 1'b0;
      mem_byte_en        <= '0;
      mem_address        <= '0;
      mem_data_out       <= '0;
    end else begin
      fetch_valid        <= 1'b0;
      memory_valid       <= 1'b0;
      i_mem_access_fault <= 1'b0;
      d_mem_access_fault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_fetch_pend || w_data_pend) begin
            r_state <= ISSUE;
            if (w_grant_data) begin
              r_req_id     <= REQ_DATA;
              mem_read     <= (w_data_op == OP_READ);
              mem_write    <= (w_data_op == OP_WRITE);
              mem_byte_en  <= memory_byte_en;
              mem_address  <= memory_address_out;
              mem_data_out <= memory_data_out;
              if (!w_fetch_pend) begin
                r_streak <= '0;
              end else if (r_streak != c_streak_max) begin
                r_streak <= r_streak + 1'b1;
              end
            end else begin
              r_req_id     <= REQ_FETCH;
              mem_read     <= 1'b1;
              mem_write    <= 1'b0;
              mem_byte_en  <= '1;
              mem_address  <= fetch_address_out;
              mem_data_out <= '0;
              r_streak     <= '0;
            end
          end
        end
        ISSUE: begin
          // A response here is a protocol error and is ignored
          if (w_expired) begin
            mem_read           <= 1'b0;
            mem_write          <= 1'b0;
            i_mem_access_fault <= (r_req_id == REQ_FETCH);
            d_mem_access_fault <= (r_req_id == REQ_DATA);
            r_state            <= IDLE;
          end else if (mem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          // A response arriving on the expiry cycle still wins over the fault
          if (mem_valid) begin
            if (r_req_id == REQ_FETCH) begin
              fetch_valid      <= 1'b1;
              fetch_data_in    <= mem_data_in;
              fetch_address_in <= mem_address_in;
            end else begin
              memory_valid      <= 1'b1;
              memory_data_in    <= mem_data_in;
              memory_address_in <= mem_address_in;
            end
            r_state <= IDLE;
          end else if (w_expired) begin
            i_mem_access_fault <= (r_req_id == REQ_FETCH);
            d_mem_access_fault <= (r_req_id == REQ_DATA);
            r_state            <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_unified_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_unified_memory_arbiter
// Description : Directed self-checking bench for unified_memory_arbiter with
//               a zero-wait downstream responder that can be switched off.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_memory_arbiter;

  localparam int DW = 128;
  localparam int AW = 64;
  localparam int NB = DW / 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          fetch_read;
  logic [AW-1:0] fetch_address_out;
  logic          fetch_ready, fetch_valid;
  logic [DW-1:0] fetch_data_in;
  logic [AW-1:0] fetch_address_in;
  logic          memory_read, memory_write;
  logic [NB-1:0] memory_byte_en;
  logic [AW-1:0] memory_address_out;
  logic [DW-1:0] memory_data_out;
  logic          memory_ready, memory_valid;
  logic [DW-1:0] memory_data_in;
  logic [AW-1:0] memory_address_in;
  logic          i_mem_access_fault, d_mem_access_fault;
  logic          mem_read, mem_write;
  logic [NB-1:0] mem_byte_en;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_out;
  logic          mem_ready;
  logic          mem_valid;
  logic [DW-1:0] mem_data_in;
  logic [AW-1:0] mem_address_in;

  int n_vectors     = 0;
  int n_miscompares = 0;

  logic          auto_resp;
  logic          resp_armed;
  logic [DW-1:0] resp_data;
  logic [AW-1:0] resp_addr;

  unified_memory_arbiter #(
    .DATA_WIDTH      (DW),
    .ADDRESS_BITS    (AW),
    .NUM_BYTES       (NB),
    .TIMEOUT_CYCLES  (8),
    .MAX_DATA_STREAK (4)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .fetch_read         (fetch_read),
    .fetch_address_out  (fetch_address_out),
    .fetch_ready        (fetch_ready),
    .fetch_valid        (fetch_valid),
    .fetch_data_in      (fetch_data_in),
    .fetch_address_in   (fetch_address_in),
    .memory_read        (memory_read),
    .memory_write       (memory_write),
    .memory_byte_en     (memory_byte_en),
    .memory_address_out (memory_address_out),
    .memory_data_out    (memory_data_out),
    .memory_ready       (memory_ready),
    .memory_valid       (memory_valid),
    .memory_data_in     (memory_data_in),
    .memory_address_in  (memory_address_in),
    .i_mem_access_fault (i_mem_access_fault),
    .d_mem_access_fault (d_mem_access_fault),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .mem_byte_en        (mem_byte_en),
    .mem_address        (mem_address),
    .mem_data_out       (mem_data_out),
    .mem_ready          (mem_ready),
    .mem_valid          (mem_valid),
    .mem_data_in        (mem_data_in),
    .mem_address_in     (mem_address_in)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; sample/drive 1 time unit after the rising edge.
  // A command seen accepted is answered on the following cycle.
  task automatic tick();
    @(posedge clock);
    #1;
    if (resp_armed) begin
      mem_valid      = 1'b1;
      mem_data_in    = resp_data;
      mem_address_in = resp_addr;
      resp_armed     = 1'b0;
    end else begin
      mem_valid = 1'b0;
    end
    if (auto_resp && (mem_read || mem_write) && mem_ready) begin
      resp_armed = 1'b1;
      resp_addr  = mem_address;
    end
  endtask

  logic [6:0] exp_order = 7'b1101111;   // bit g: 1 = data grant, 0 = fetch grant
  logic       is_data;
  int         loads_left;
  int         d_cnt, d_cyc, mv_cnt, mv_cyc;
  logic       fv_seen, mv_seen, if_seen;

  initial begin
    reset              = 1'b0;
    fetch_read         = 1'b0;
    fetch_address_out  = '0;
    memory_read        = 1'b0;
    memory_write       = 1'b0;
    memory_byte_en     = '0;
    memory_address_out = '0;
    memory_data_out    = '0;
    mem_ready          = 1'b1;
    mem_valid          = 1'b0;
    mem_data_in        = '0;
    mem_address_in     = '0;
    auto_resp          = 1'b1;
    resp_armed         = 1'b0;
    resp_data          = '0;
    resp_addr          = '0;

    // ---------------- reset state ----------------
    tick();
    tick();
    check_val("rst_fetch_ready", 128'(fetch_ready), 128'(1));
    check_val("rst_memory_ready", 128'(memory_ready), 128'(1));
    check_val("rst_cmd", 128'({mem_read, mem_write, fetch_valid, memory_valid}), 128'(0));
    check_val("rst_faults", 128'({i_mem_access_fault, d_mem_access_fault}), 128'(0));
    reset = 1'b1;
    tick();

    // ---------------- fetch only ----------------
    fetch_read        = 1'b1;
    fetch_address_out = 64'h14;
    resp_data         = 128'h0000000000200613_0000000000100593;
    check_val("f_ready_c0", 128'(fetch_ready), 128'(1));
    tick();
    fetch_read = 1'b0;
    check_val("f_mem_read_c1", 128'(mem_read), 128'(1));
    check_val("f_mem_addr_c1", 128'(mem_address), 128'h14);
    check_val("f_byte_en_c1", 128'(mem_byte_en), 128'hFFFF);
    tick();
    check_val("f_cmd_drop_c2", 128'({mem_read, fetch_valid}), 128'(0));
    tick();
    check_val("f_valid_c3", 128'(fetch_valid), 128'(1));
    check_val("f_data_c3", 128'(fetch_data_in), 128'h0000000000200613_0000000000100593);
    check_val("f_addr_c3", 128'(fetch_address_in), 128'h14);
    check_val("f_ready_c3", 128'(fetch_ready), 128'(1));
    tick();
    check_val("f_valid_c4", 128'(fetch_valid), 128'(0));

    // ---------------- simultaneous requests ----------------
    fetch_read         = 1'b1;
    fetch_address_out  = 64'h20;
    memory_read        = 1'b1;
    memory_address_out = 64'h100;
    memory_byte_en     = '1;
    resp_data          = 128'hD00D;
    tick();
    memory_read = 1'b0;
    check_val("sim_first_addr", 128'(mem_address), 128'h100);
    tick();
    tick();
    check_val("sim_dvalid", 128'({memory_valid, fetch_valid}), 128'(2'b10));
    check_val("sim_daddr", 128'(memory_address_in), 128'h100);
    tick();
    fetch_read = 1'b0;
    check_val("sim_second_addr", 128'(mem_address), 128'h20);
    tick();
    tick();
    check_val("sim_fvalid", 128'({memory_valid, fetch_valid}), 128'(2'b01));
    check_val("sim_faddr", 128'(fetch_address_in), 128'h20);

    // ---------------- starvation bound ----------------
    fetch_read         = 1'b1;
    fetch_address_out  = 64'h40;
    memory_read        = 1'b1;
    memory_address_out = 64'h1000;
    loads_left         = 6;
    resp_data          = 128'h77;
    for (int g = 0; g < 7; g++) begin
      tick();
      is_data = (mem_address != 64'h40);
      check_val("grant_order", 128'(is_data), 128'(exp_order[g]));
      if (is_data) begin
        loads_left--;
        memory_address_out = memory_address_out + 64'h8;
        memory_read        = (loads_left > 0);
      end
      if (g == 6) fetch_read = 1'b0;
      tick();
      tick();
      check_val(is_data ? "starve_dvalid" : "starve_fvalid",
                128'(is_data ? memory_valid : fetch_valid), 128'(1));
    end

    // ---------------- store ----------------
    memory_write       = 1'b1;
    memory_byte_en     = 16'h000F;
    memory_data_out    = 128'hDEADBEEF;
    memory_address_out = 64'h200;
    resp_data          = 128'h55;
    fv_seen            = 1'b0;
    tick();
    fv_seen      = fv_seen | fetch_valid;
    memory_write = 1'b0;
    check_val("st_rw", 128'({mem_write, mem_read}), 128'(2'b10));
    check_val("st_byte_en", 128'(mem_byte_en), 128'h000F);
    check_val("st_data", 128'(mem_data_out), 128'hDEADBEEF);
    check_val("st_addr", 128'(mem_address), 128'h200);
    tick();
    fv_seen = fv_seen | fetch_valid;
    check_val("st_valid_c2", 128'(memory_valid), 128'(0));
    tick();
    fv_seen = fv_seen | fetch_valid;
    check_val("st_valid_c3", 128'(memory_valid), 128'(1));
    check_val("st_resp_data", 128'(memory_data_in), 128'h55);
    tick();
    fv_seen = fv_seen | fetch_valid;
    check_val("st_valid_c4", 128'(memory_valid), 128'(0));
    check_val("st_no_fvalid", 128'(fv_seen), 128'(0));

    // ---------------- timeout, no response ----------------
    auto_resp          = 1'b0;
    memory_byte_en     = '1;
    memory_read        = 1'b1;
    memory_address_out = 64'h300;
    d_cnt = 0; d_cyc = 0; mv_seen = 1'b0; if_seen = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) memory_read = 1'b0;
      if (d_mem_access_fault) begin
        d_cnt++;
        d_cyc = c;
      end
      mv_seen = mv_seen | memory_valid;
      if_seen = if_seen | i_mem_access_fault;
      if (c == 9) check_val("to_idle", 128'(memory_ready), 128'(1));
    end
    check_val("to_fault_count", 128'(d_cnt), 128'(1));
    check_val("to_fault_cycle", 128'(d_cyc), 128'(9));
    check_val("to_no_valid", 128'({mv_seen, if_seen}), 128'(0));

    // ---------------- timeout, response on 8th cycle ----------------
    memory_read        = 1'b1;
    memory_address_out = 64'h308;
    d_cnt = 0; mv_cnt = 0; mv_cyc = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) memory_read = 1'b0;
      if (d_mem_access_fault) d_cnt++;
      if (memory_valid) begin
        mv_cnt++;
        mv_cyc = c;
      end
      if (c == 8) begin
        mem_valid      = 1'b1;
        mem_data_in    = 128'hABC;
        mem_address_in = 64'h308;
      end
    end
    check_val("late_no_fault", 128'(d_cnt), 128'(0));
    check_val("late_valid_count", 128'(mv_cnt), 128'(1));
    check_val("late_valid_cycle", 128'(mv_cyc), 128'(9));
    check_val("late_data", 128'(memory_data_in), 128'hABC);

    // ---------------- reset mid-WAIT ----------------
    fetch_read        = 1'b1;
    fetch_address_out = 64'h80;
    tick();
    fetch_read = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    check_val("mrst_fetch_data", 128'(fetch_data_in), 128'(0));
    check_val("mrst_mem_data", 128'(memory_data_in), 128'(0));
    check_val("mrst_cmd", 128'({mem_read, mem_write, mem_byte_en, mem_address}), 128'(0));
    check_val("mrst_readies", 128'({fetch_ready, memory_ready}), 128'(2'b11));
    tick();
    reset          = 1'b1;
    mem_valid      = 1'b1;
    mem_data_in    = 128'hBAD;
    mem_address_in = 64'h80;
    tick();
    check_val("mrst_late_ignored", 128'({fetch_valid, memory_valid}), 128'(0));
    check_val("mrst_late_data", 128'(fetch_data_in), 128'(0));
    auto_resp         = 1'b1;
    resp_data         = 128'h1234;
    fetch_read        = 1'b1;
    fetch_address_out = 64'h90;
    tick();
    fetch_read = 1'b0;
    check_val("post_mem_read", 128'(mem_read), 128'(1));
    tick();
    tick();
    check_val("post_fvalid", 128'(fetch_valid), 128'(1));
    check_val("post_fdata", 128'(fetch_data_in), 128'h1234);
    check_val("post_faddr", 128'(fetch_address_in), 128'h90);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/unified_memory_arbiter.md
# unified_memory_arbiter

Shares one downstream memory port between the seven-stage privileged core's fetch interface and its data (load/store) interface. It serializes requests with a single-outstanding-transaction FSM and routes responses back with the echoed address. Data requests have priority, bounded by a fetch-starvation limit. A response timeout raises the core's instruction or data access-fault input. It sits between the core's `fetch_*`/`memory_*` ports and the L1/unified memory.

## Interface
Parameters:
- `DATA_WIDTH`, 64: data bus width.
- `ADDRESS_BITS`, 64: address width.
- `NUM_BYTES`, DATA_WIDTH/8: byte-enable width.
- `TIMEOUT_CYCLES`, 255: maximum cycles in ISSUE+WAIT before a fault is raised; must be ≥2.
- `MAX_DATA_STREAK`, 4: consecutive data grants allowed while fetch is pending.

Ports:
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `fetch_read` in 1, `fetch_address_out` in ADDRESS_BITS: core fetch request, held until `fetch_valid` or fault.
- `fetch_ready` out 1, `fetch_valid` out 1, `fetch_data_in` out DATA_WIDTH, `fetch_address_in` out ADDRESS_BITS: fetch acceptance and response to the core.
- `memory_read` in 1, `memory_write` in 1, `memory_byte_en` in NUM_BYTES, `memory_address_out` in ADDRESS_BITS, `memory_data_out` in DATA_WIDTH: core data request.
- `memory_ready` out 1, `memory_valid` out 1, `memory_data_in` out DATA_WIDTH, `memory_address_in` out ADDRESS_BITS: data acceptance and response to the core.
- `i_mem_access_fault` out 1, `d_mem_access_fault` out 1: one-cycle timeout fault pulses to the core.
- `mem_read` out 1, `mem_write` out 1, `mem_byte_en` out NUM_BYTES, `mem_address` out ADDRESS_BITS, `mem_data_out` out DATA_WIDTH: downstream command.
- `mem_ready` in 1: downstream accepts the command this cycle.
- `mem_valid` in 1, `mem_data_in` in DATA_WIDTH, `mem_address_in` in ADDRESS_BITS: downstream response. A response is returned for both reads and writes.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- `fetch_ready` = `memory_ready` = (state==IDLE).
- **IDLE**
  - Pending requests: fetch_pend = `fetch_read`; data_pend = `memory_read|memory_write`.
  - If only one is pending, grant it.
  - If both are pending, grant data unless streak==MAX_DATA_STREAK, in which case grant fetch.
  - On grant, latch requester ID, op, address, write data and byte_en (fetch: read, byte_en all ones). Next state is ISSUE.
- **Streak counter**
  - Increments on each data grant made while fetch_pend.
  - Clears on a fetch grant, or on any data grant made without fetch_pend.
  - Saturates at MAX_DATA_STREAK.
- **ISSUE**
  - `mem_read`/`mem_write` are driven from the latched op, with the latched address, data and byte_en.
  - On `mem_ready`=1: command lines drop next cycle; next state is WAIT.
- **WAIT**
  - On `mem_valid`=1, register `mem_data_in`/`mem_address_in` into the granted requester's data/address outputs.
  - Pulse that requester's `*_valid` for exactly one cycle; next state is IDLE.
  - For writes, `memory_data_in` takes `mem_data_in` unchanged; the core ignores it.
- **Timeout**
  - The counter clears on entry to ISSUE and increments each cycle in ISSUE or WAIT.
  - When the count reaches TIMEOUT_CYCLES-1 with no `mem_valid`:
    - pulse `i_mem_access_fault` (fetch grant) or `d_mem_access_fault` (data grant) for one cycle;
    - deassert the command; next state is IDLE;
    - do not assert `*_valid`.
  - `mem_valid` and timeout in the same cycle: the response wins and no fault is raised.
- `mem_valid` seen in IDLE or ISSUE is a protocol error: it is ignored and no output changes.
- A request withdrawn after grant does not cancel the transaction; the response is still delivered.
- A `memory_read` and `memory_write` asserted together are treated as a write.

## Timing
- **Reset** (`reset`=0, asynchronous): state=IDLE, counters=0.
  - All outputs are 0, except `fetch_ready`=`memory_ready`=1 (combinational from IDLE).
  - Reset mid-transaction abandons it silently; a late `mem_valid` after reset falls under the IDLE rule.
- **Latency**, zero-wait memory (`mem_ready` and `mem_valid` each high on their first possible cycle):
  - request sampled in IDLE at cycle 0;
  - `mem_read`/`mem_write` high at cycle 1;
  - `mem_valid` sampled at cycle 2;
  - `*_valid` high at cycle 3;
  - `*_ready` high again at cycle 3, so the next grant is sampled at cycle 3.
- Best-case throughput: one transaction per 3 cycles.
- All core-side and downstream outputs are registered, except `*_ready`.

## Structure
- Shared package `mem_arb_pkg` holds:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2);
  - requester IDs (REQ_FETCH=1'b0, REQ_DATA=1'b1);
  - the op encoding.
- One sub-module, `mem_arb_timeout_counter` (parameter TIMEOUT_CYCLES), with clear/enable inputs and an `expired` output. It is reusable for the page-table-walker port.

## Test plan
- **Fetch only:** `fetch_read`=1, addr 0x14, zero-wait memory returning 0x0000000000200613_0000000000100593.
  - `mem_read` at cycle 1; `fetch_valid` for one cycle at cycle 3 with that data and `fetch_address_in`=0x14.
- **Simultaneous requests:** fetch 0x20 and load 0x100 in the same IDLE cycle.
  - Data is granted first (`mem_address`=0x100); fetch is served in the next transaction.
- **Starvation bound:** fetch held with 6 back-to-back loads, MAX_DATA_STREAK=4.
  - Grant order: D,D,D,D,F,D,D; the streak counter clears after the fetch grant.
- **Store:** `memory_write`=1, byte_en 0x0F, data 0xDEADBEEF at 0x200.
  - `mem_write`=1 with identical byte_en/data/address; `memory_valid` pulses once.
  - `fetch_valid` stays 0 throughout.
- **Timeout:** TIMEOUT_CYCLES=8, `mem_ready`=1, `mem_valid` never asserted on a load.
  - `d_mem_access_fault` pulses once, 8 cycles after ISSUE entry; FSM returns to IDLE; `memory_valid` stays 0.
  - Repeat with `mem_valid` on the 8th cycle: no fault, response delivered.
- **Reset mid-WAIT:** `reset`=0 for 1 cycle during a fetch.
  - All outputs 0 immediately; `*_ready`=1; a following `mem_valid` is ignored; a new fetch then completes normally.
